// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes and data-memory wait
// freezing with a watchdog that latches a sticky timeout error.
module hazard_stall_ctrl #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rd,
  input  logic [4:0]  ifid_rs1,
  input  logic [4:0]  ifid_rs2,
  input  logic        exmem_memaccess,
  input  logic        dmem_ready,
  input  logic        branch_taken,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_bubble,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        pipe_hold,
  output logic        dmem_req,
  output logic        mem_timeout,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt, wait_cnt_nxt;
  logic        timeout_set;
  logic        mem_timeout_q;
  logic [15:0] stall_cycles_q;
  logic        load_use;
  logic        mem_stall;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign load_use  = idex_memread && (idex_rd != 5'd0) &&
                     ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));
  assign mem_stall = exmem_memaccess && !dmem_ready;

  // state register and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= RUN;
      wait_cnt       <= 8'd0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= 16'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (timeout_set)
        mem_timeout_q <= 1'b1;
      if (!pc_write)
        stall_cycles_q <= sat_inc16(stall_cycles_q);
    end
  end

  // next-state logic
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    timeout_set  = 1'b0;
    case (state)
      RUN: begin
        if (mem_stall) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_nxt    = RUN;
          wait_cnt_nxt = 8'd0;
        end else if (wait_cnt < MAX_WAIT_C) begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end else begin
          state_nxt   = ERROR;
          timeout_set = 1'b1;
        end
      end
      ERROR:   state_nxt = ERROR;
      default: state_nxt = RUN;
    endcase
  end

  // output decode
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    pipe_hold   = 1'b0;
    dmem_req    = 1'b0;
    if (reset) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else begin
      case (state)
        RUN, MEM_WAIT: begin
          if ((state == RUN && mem_stall) || (state == MEM_WAIT && !dmem_ready)) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
            dmem_req   = 1'b1;
          end else begin
            // the completing access still owns the memory port this cycle
            dmem_req = (state == MEM_WAIT);
            if (branch_taken) begin
              ifid_flush = 1'b1;
              idex_flush = 1'b1;
            end else if (load_use) begin
              pc_write    = 1'b0;
              ifid_write  = 1'b0;
              idex_bubble = 1'b1;
            end
          end
        end
        ERROR: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          pipe_hold  = 1'b1;
        end
        default: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
        end
      endcase
    end
  end

  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a behavioural model.
module tb_hazard_stall_ctrl;

  localparam int MAXW = 4;

  logic        clk;
  logic        reset;
  logic        idex_memread;
  logic [4:0]  idex_rd, ifid_rs1, ifid_rs2;
  logic        exmem_memaccess, dmem_ready, branch_taken;
  logic        pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush;
  logic        pipe_hold, dmem_req, mem_timeout;
  logic [15:0] stall_cycles;

  int vectors = 0;
  int miscompares = 0;

  // behavioural model: how long the access has been outstanding, error flag, stall tally
  int m_waited = 0;
  bit m_error  = 0;
  int m_stalls = 0;

  hazard_stall_ctrl #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .exmem_memaccess(exmem_memaccess),
    .dmem_ready(dmem_ready), .branch_taken(branch_taken), .pc_write(pc_write),
    .ifid_write(ifid_write), .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .pipe_hold(pipe_hold), .dmem_req(dmem_req),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bit order: pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, pipe_hold, dmem_req
  function automatic logic [6:0] outv();
    return {pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, pipe_hold, dmem_req};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle compare against the model, then advance the model across the coming edge
  always @(negedge clk) begin
    logic       lu, ms;
    logic [6:0] e;
    lu = idex_memread && (idex_rd != 0) && (idex_rd == ifid_rs1 || idex_rd == ifid_rs2);
    ms = exmem_memaccess && !dmem_ready;
    e  = 7'b1100000;
    if (reset) e = 7'b0000000;
    else if (m_error) e = 7'b0000010;
    else if ((m_waited > 0 && !dmem_ready) || (m_waited == 0 && ms)) e = 7'b0000011;
    else begin
      if (m_waited > 0) e[0] = 1'b1;
      if (branch_taken) begin
        e[3] = 1'b1; e[2] = 1'b1;
      end else if (lu) begin
        e[6] = 1'b0; e[5] = 1'b0; e[4] = 1'b1;
      end
    end
    chk("outputs", 32'(outv()), 32'(e));
    chk("stall_cycles", 32'(stall_cycles), reset ? 32'd0 : 32'(m_stalls));
    chk("mem_timeout", 32'(mem_timeout), reset ? 32'd0 : 32'(m_error));
    if (reset) begin
      m_waited = 0; m_error = 0; m_stalls = 0;
    end else begin
      if (!e[6]) m_stalls = (m_stalls < 65535) ? m_stalls + 1 : 65535;
      if (!m_error) begin
        if (m_waited > 0) begin
          if (dmem_ready) m_waited = 0;
          else if (m_waited < MAXW) m_waited++;
          else m_error = 1'b1;
        end else if (ms) m_waited = 1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    idex_memread = 0; idex_rd = 0; ifid_rs1 = 0; ifid_rs2 = 0;
    exmem_memaccess = 0; dmem_ready = 0; branch_taken = 0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    cyc(); #2;
    chk("reset_outputs", 32'(outv()), 32'h0);
    chk("reset_stall", 32'(stall_cycles), 32'd0);
    cyc(); reset = 1'b0;

    // load-use bubble
    cyc(); idex_memread = 1; idex_rd = 5; ifid_rs1 = 1; ifid_rs2 = 5; #2;
    chk("lu_bubble", 32'(outv()), 32'b0010000);
    cyc(); idle(); #2;
    chk("lu_after", 32'(outv()), 32'b1100000);
    chk("lu_stall_cnt", 32'(stall_cycles), 32'd1);
    chk("model_stall_cnt", 32'(m_stalls), 32'd1);

    // x0 destination is never a hazard; branch overrides load-use
    cyc(); idex_memread = 1; idex_rd = 0; ifid_rs1 = 0; ifid_rs2 = 0; #2;
    chk("lu_x0", 32'(outv()), 32'b1100000);
    cyc(); idex_rd = 7; ifid_rs1 = 7; branch_taken = 1; #2;
    chk("branch_lu", 32'(outv()), 32'b1101100);
    cyc(); idle(); #2;
    chk("branch_stall_cnt", 32'(stall_cycles), 32'd1);

    // memory wait of three cycles, then completion
    for (int i = 0; i < 3; i++) begin
      cyc(); exmem_memaccess = 1; dmem_ready = 0; #2;
      chk("mem_hold", 32'(outv()), 32'b0000011);
    end
    cyc(); dmem_ready = 1; #2;
    chk("mem_done", 32'(outv()), 32'b1100001);
    cyc(); idle(); dmem_ready = 1; #2;
    chk("ready_ignored_run", 32'(outv()), 32'b1100000);
    chk("mem_stall_cnt", 32'(stall_cycles), 32'd4);

    // reset in the second cycle of a memory wait
    cyc(); exmem_memaccess = 1; dmem_ready = 0;
    cyc(); #2;
    chk("wait2_hold", 32'(outv()), 32'b0000011);
    reset = 1'b1; #1;
    chk("midwait_reset_out", 32'(outv()), 32'h0);
    chk("midwait_reset_cnt", 32'(stall_cycles), 32'd0);
    cyc(); reset = 1'b0; idle(); #2;
    chk("after_reset_run", 32'(outv()), 32'b1100000);

    // watchdog timeout with MAX_WAIT=4
    for (int i = 0; i < MAXW + 1; i++) begin
      cyc(); exmem_memaccess = 1; dmem_ready = 0; #2;
      chk("to_hold", 32'(outv()), 32'b0000011);
    end
    cyc(); #2;
    chk("err_out", 32'(outv()), 32'b0000010);
    chk("err_timeout", 32'(mem_timeout), 32'd1);
    cyc(); idle(); dmem_ready = 1; branch_taken = 1; #2;
    chk("err_sticky", 32'(outv()), 32'b0000010);
    cyc(); reset = 1'b1;
    cyc(); reset = 1'b0; idle(); #2;
    chk("err_cleared", 32'(mem_timeout), 32'd0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cyc();
      reset           = ($urandom_range(0, 149) == 0);
      idex_memread    = 1'($urandom_range(0, 1));
      idex_rd         = 5'($urandom_range(0, 3));
      ifid_rs1        = 5'($urandom_range(0, 3));
      ifid_rs2        = 5'($urandom_range(0, 3));
      exmem_memaccess = ($urandom_range(0, 3) == 0);
      dmem_ready      = 1'($urandom_range(0, 1));
      branch_taken    = ($urandom_range(0, 3) == 0);
    end

    // stall counter saturation
    cyc(); reset = 1'b1; idle();
    cyc(); reset = 1'b0;
    idex_memread = 1; idex_rd = 3; ifid_rs1 = 3;
    for (int i = 0; i < 65540; i++) cyc();
    #2;
    chk("stall_saturated", 32'(stall_cycles), 32'hFFFF);
    cyc(); #2;
    chk("stall_no_wrap", 32'(stall_cycles), 32'hFFFF);
    idle();
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
